// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and 2-entry skid.
// Optional statistics counters: define PIPE_STAGE_STAT_EN.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
`ifdef PIPE_STAGE_STAT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STAT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              in_ready_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

    logic acc_in;
    logic main_valid;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid_in;
    logic clr_skid;

    assign acc_in     = in_valid & in_ready_q;
    assign main_valid = (state_q != EMPTY);

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        clr_skid     = 1'b0;
        if (!flush) begin
            unique case (state_q)
                EMPTY: begin
                    if (acc_in) begin
                        state_d    = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc_in && out_ready) begin
                        ld_main_in = 1'b1;
                    end else if (acc_in) begin
                        state_d    = FULL;
                        ld_skid_in = 1'b1;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d      = ONE;
                        ld_main_skid = 1'b1;
                        clr_skid     = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            state_d = EMPTY;
        end
    end

    // in_ready comes straight from a flop: no path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else if (flush) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else if (ld_main_in) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
        end else if (ld_main_skid) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush || clr_skid) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (ld_skid_in) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data_q;
    // Bubbles must look like NOPs downstream.
    assign out_ctrl  = main_ctrl_q & {CTRL_W{main_valid}};

`ifdef PIPE_STAGE_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_valid && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid.
// Counter checks run when PIPE_STAGE_STAT_EN is defined.
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_STAT_EN
    logic [3:0]        stall_cnt;
    logic [3:0]        flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_stage_skid #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
`ifdef PIPE_STAGE_STAT_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STAT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_ctrl", 32'(out_ctrl), 32'd0);

        // Fill to FULL with 0xA / 0xB, then reset mid-transfer
        in_valid = 1'b1;
        in_data  = 32'hA;
        in_ctrl  = 8'h3C;
        step();
        in_data = 32'hB;
        in_ctrl = 8'hC3;
        step();
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", out_data, 32'hA);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        step();
        check("rstfull_out_valid", 32'(out_valid), 32'd0);
        check("rstfull_out_data", out_data, 32'd0);
        check("rstfull_out_ctrl", 32'(out_ctrl), 32'd0);
        check("rstfull_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();
        check("rstfull_after_valid", 32'(out_valid), 32'd0);

        // Streaming pass-through
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            in_ctrl = 8'(i);
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", out_data, 32'(i));
            check("stream_ctrl", 32'(out_ctrl), 32'(i));
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_ctrl_bubble", 32'(out_ctrl), 32'd0);

        // Back-pressure into the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h10;
        in_ctrl   = 8'h11;
        step();
        check("bp_one_data", out_data, 32'h10);
        check("bp_one_in_ready", 32'(in_ready), 32'd1);
        in_data = 32'h11;
        in_ctrl = 8'h22;
        step();
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_full_data", out_data, 32'h10);
        in_valid = 1'b0;
        in_data  = 32'hDEAD;
        step();
        check("bp_hold_data", out_data, 32'h10);
        check("bp_hold_ctrl", 32'(out_ctrl), 32'h11);
        check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_head", out_data, 32'h10);
        step();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_data", out_data, 32'h11);
        check("bp_second_ctrl", 32'(out_ctrl), 32'h22);
        check("bp_second_in_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush while FULL, with out_ready asserted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h20;
        in_ctrl   = 8'h5A;
        step();
        in_data = 32'h21;
        in_ctrl = 8'hA5;
        step();
        check("fl_full_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_ctrl", 32'(out_ctrl), 32'd0);
        check("fl_out_data", out_data, 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        step();
        check("fl_no_beat", 32'(out_valid), 32'd0);

        // Beat offered in the flush cycle is dropped
        in_valid = 1'b1;
        in_data  = 32'h55;
        in_ctrl  = 8'hFF;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flin_out_valid", 32'(out_valid), 32'd0);
        check("flin_out_ctrl", 32'(out_ctrl), 32'd0);
        step();
        check("flin_after_valid", 32'(out_valid), 32'd0);
        check("flin_after_ctrl", 32'(out_ctrl), 32'd0);

`ifdef PIPE_STAGE_STAT_EN
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("cnt_rst_stall", 32'(stall_cnt), 32'd0);
        check("cnt_rst_flush", 32'(flush_cnt), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h30;
        in_ctrl  = 8'h01;
        step();
        in_valid = 1'b0;
        check("cnt_stall_start", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("cnt_stall_sat", 32'(stall_cnt), 32'hF);
        flush = 1'b1;
        step();
        step();
        step();
        flush = 1'b0;
        step();
        check("cnt_flush", 32'(flush_cnt), 32'd3);
        check("cnt_stall_hold", 32'(stall_cnt), 32'hF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
